// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: slice width and saturation constants.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
// The handshake is a plain valid/ready freeze, so no state encoding lives here.
package pipe_adder_pkg;

   // Widest operand the saturation helpers can produce.
   localparam int MAX_W = 256;

   function automatic int slice_w(input int n, input int stages);
      return n / stages;
   endfunction

   // Most positive two's-complement value of width n (0x7F..F), zero-extended.
   function automatic logic [MAX_W-1:0] sat_pos(input int n);
      return {MAX_W{1'b1}} >> (MAX_W - n + 1);
   endfunction

   // Most negative two's-complement value of width n (0x80..0), zero-extended.
   function automatic logic [MAX_W-1:0] sat_neg(input int n);
      return {{(MAX_W-1){1'b0}}, 1'b1} << (n - 1);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One W-bit slice of the pipelined adder: registered sum slice, carry-out and valid.
// Latency: 1 cycle.
// Backpressure: every register holds while i_adv is low.
// Ports: clk/rst (sync, active-high); i_adv pipe advance; i_vld/i_a/i_b/i_cin slice
//        inputs; o_vld/o_sum/o_cout registered slice result.
module pipe_adder_stage #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_adv,
   input  logic         i_vld,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic         o_vld,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W:0]   w_add;
   logic         r_vld;
   logic [W-1:0] r_sum;
   logic         r_cout;

   assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

   // Data is captured even for bubbles; only r_vld says whether it means anything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (i_adv) begin
         r_vld  <= i_vld;
         r_sum  <= w_add[W-1:0];
         r_cout <= w_add[W];
      end
   end

   assign o_vld  = r_vld;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined N-bit add/subtract, one W=N/STAGES slice per clock, carry registered between slices.
// Latency: STAGES cycles from accept to out_valid; throughput 1 per cycle.
// Backpressure: in_ready = !out_valid || out_ready; when low the whole pipe freezes (no bubble collapse).
// Ports: clk, rst (sync, active-high); in_valid/in_ready/a/b/cin/sub operand side;
//        out_valid/out_ready/sum/cout/ovf result side (cout is the raw MSB carry, ovf signed overflow).
// Optional macro PIPE_ADDER_SAT_EN: saturate sum on signed overflow at the output.
module pipe_adder #(
   parameter int N      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   import pipe_adder_pkg::*;

   localparam int W = slice_w(N, STAGES);

   if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: N (%0d) must be divisible by STAGES (%0d)", N, STAGES);
   end

`ifdef PIPE_ADDER_SAT_EN
   localparam logic [N-1:0] SAT_POS = N'(sat_pos(N));
   localparam logic [N-1:0] SAT_NEG = N'(sat_neg(N));
`endif

   logic              w_adv;
   logic [N-1:0]      w_effb;
   logic              w_effcin;
   logic [STAGES-1:0] w_vld;
   logic [STAGES-1:0] w_cout;
   logic [W-1:0]      w_sum     [STAGES];
   logic [W-1:0]      w_aligned [STAGES];
   logic [N-1:0]      w_raw;
   logic              w_a_msb;
   logic              w_b_msb;

   assign w_adv    = !w_vld[STAGES-1] || out_ready;
   assign in_ready = w_adv;

   // Subtraction folded in at entry: a - b - cin == a + ~b + !cin.
   assign w_effb   = b ^ {N{sub}};
   assign w_effcin = cin ^ sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic [W-1:0] w_op_a;
      logic [W-1:0] w_op_b;
      logic         w_ci;
      logic         w_vi;

      if (k == 0) begin : g_entry
         assign w_op_a = a[W-1:0];
         assign w_op_b = w_effb[W-1:0];
         assign w_ci   = w_effcin;
         assign w_vi   = in_valid;
      end else begin : g_skew
         // Slice k waits k cycles so it meets the carry rippling up from slice k-1.
         logic [W-1:0] r_a_d [k];
         logic [W-1:0] r_b_d [k];

         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_a_d[0] <= a[k*W +: W];
               r_b_d[0] <= w_effb[k*W +: W];
               for (int i = 1; i < k; i++) begin
                  r_a_d[i] <= r_a_d[i-1];
                  r_b_d[i] <= r_b_d[i-1];
               end
            end
         end

         assign w_op_a = r_a_d[k-1];
         assign w_op_b = r_b_d[k-1];
         assign w_ci   = w_cout[k-1];
         assign w_vi   = w_vld[k-1];
      end

      pipe_adder_stage #(.W(W)) u_stage (
         .clk    (clk),
         .rst    (rst),
         .i_adv  (w_adv),
         .i_vld  (w_vi),
         .i_a    (w_op_a),
         .i_b    (w_op_b),
         .i_cin  (w_ci),
         .o_vld  (w_vld[k]),
         .o_sum  (w_sum[k]),
         .o_cout (w_cout[k])
      );

      if (k == STAGES - 1) begin : g_msb
         // Operand sign bits travel with the top slice so overflow is judged on the same item.
         logic r_a_msb;
         logic r_b_msb;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_a_msb <= 1'b0;
               r_b_msb <= 1'b0;
            end else if (w_adv) begin
               r_a_msb <= w_op_a[W-1];
               r_b_msb <= w_op_b[W-1];
            end
         end

         assign w_a_msb = r_a_msb;
         assign w_b_msb = r_b_msb;
      end

      if (k < STAGES - 1) begin : g_deskew
         // Finished lower slices wait for the top slice so the word leaves aligned.
         localparam int D = STAGES - 1 - k;
         logic [W-1:0] r_s_d [D];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < D; i++) r_s_d[i] <= '0;
            end else if (w_adv) begin
               r_s_d[0] <= w_sum[k];
               for (int i = 1; i < D; i++) r_s_d[i] <= r_s_d[i-1];
            end
         end

         assign w_aligned[k] = r_s_d[D-1];
      end else begin : g_top
         assign w_aligned[k] = w_sum[k];
      end
   end

   always_comb begin
      w_raw = '0;
      for (int k = 0; k < STAGES; k++) w_raw[k*W +: W] = w_aligned[k];
   end

   assign out_valid = w_vld[STAGES-1];
   assign cout      = w_cout[STAGES-1];
   assign ovf       = (w_a_msb == w_b_msb) && (w_raw[N-1] != w_a_msb);

`ifdef PIPE_ADDER_SAT_EN
   assign sum = ovf ? (w_a_msb ? SAT_NEG : SAT_POS) : w_raw;
`else
   assign sum = w_raw;
`endif

endmodule
